// File: rtl/burst_sequencer_pkg.sv
// Shared types for the tick-driven pulse blocks.
// Latency: n/a (types and defaults only).
// Backpressure: n/a.
// Contents: state enum for the burst sequencer, default field widths.
package pulse_pkg;

  // Default phase-length width; matches the upstream pulse generator counter.
  localparam int DEF_WIDTH = 4;
  // Default burst-length / remaining-pulse counter width.
  localparam int DEF_CNT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARM  = 3'd1,
    ST_HIGH = 3'd2,
    ST_LOW  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/burst_sequencer_if.sv
// Control/status bundle between a burst requester and burst_sequencer.
// Latency: n/a (wires only).
// Backpressure: none; start is only honoured while the sequencer is idle.
// master: drives tick/start/abort/config, observes pwm_out/busy/done/remaining.
// slave : the sequencer side of the same signals.
interface burst_sequencer_if
  import pulse_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
);

  logic             tick;
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] high_ticks;
  logic [WIDTH-1:0] low_ticks;
  logic [CNT_W-1:0] burst_len;
  logic             pwm_out;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] remaining;

  modport master (
    output tick, start, abort, high_ticks, low_ticks, burst_len,
    input  pwm_out, busy, done, remaining
  );

  modport slave (
    input  tick, start, abort, high_ticks, low_ticks, burst_len,
    output pwm_out, busy, done, remaining
  );

endinterface

// File: rtl/burst_sequencer.sv
// Emits burst_len pulses on pwm_out, high/low phases counted in upstream ticks.
// Latency: start accepted at edge N -> busy after N; first rise on the next tick.
// Backpressure: none; start ignored while busy, abort returns to idle next edge.
// Ports: clk, rst (sync, active-low), bus (slave modport: tick, start, abort,
//        high_ticks, low_ticks, burst_len in; pwm_out, busy, done, remaining out).
module burst_sequencer
  import pulse_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  burst_sequencer_if.slave bus
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ph_q, ph_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             pwm_q, busy_q, done_q;
  logic [WIDTH-1:0] hi_eff, lo_eff;

  // Zero-length phases behave as one tick.
  assign hi_eff = (hi_q == '0) ? WIDTH'(1) : hi_q;
  assign lo_eff = (lo_q == '0) ? WIDTH'(1) : lo_q;

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    rem_d   = rem_q;

    case (state_q)
      ST_IDLE: begin
        // A tick coinciding with acceptance is deliberately not consumed;
        // ARM waits for the following one.
        if (bus.start && (bus.burst_len != '0)) begin
          hi_d    = bus.high_ticks;
          lo_d    = bus.low_ticks;
          rem_d   = bus.burst_len;
          ph_d    = '0;
          state_d = ST_ARM;
        end
      end
      ST_ARM: begin
        if (bus.tick) begin
          ph_d    = '0;
          state_d = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (bus.tick) begin
          if (ph_q == hi_eff - WIDTH'(1)) begin
            ph_d = '0;
            if (rem_q != '0) begin
              rem_d = rem_q - CNT_W'(1);
            end
            // The final pulse has no trailing low phase.
            state_d = (rem_q <= CNT_W'(1)) ? ST_DONE : ST_LOW;
          end else begin
            ph_d = ph_q + WIDTH'(1);
          end
        end
      end
      ST_LOW: begin
        if (bus.tick) begin
          if (ph_q == lo_eff - WIDTH'(1)) begin
            ph_d    = '0;
            state_d = ST_HIGH;
          end else begin
            ph_d = ph_q + WIDTH'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort overrides any same-cycle tick progress; it is a no-op in idle so
    // a simultaneous start still wins there.
    if (bus.abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      rem_d   = '0;
      ph_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      ph_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      rem_q   <= '0;
      pwm_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      rem_q   <= rem_d;
      // Outputs registered from next state so they line up with the state.
      pwm_q   <= (state_d == ST_HIGH);
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= (state_d == ST_DONE);
    end
  end

  assign bus.pwm_out   = pwm_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.remaining = rem_q;

endmodule

// File: tb/tb_burst_sequencer.sv
// Self-checking bench for burst_sequencer: directed scenarios plus random bursts,
// every cycle compared against a tick-count model of the pulse train.
module tb_burst_sequencer;

  localparam int W = 4;
  localparam int C = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  burst_sequencer_if #(.WIDTH(W), .CNT_W(C)) bus ();

  burst_sequencer #(.WIDTH(W), .CNT_W(C)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int passed = 0;
  int total  = 0;

  // Tick source: tper>0 -> one tick every tper clocks, tper==0 -> random ticks.
  int tper = 5;
  int tph  = 0;

  // Reference model: a burst is described by how many ticks have been seen
  // since acceptance; the pulse train position follows arithmetically.
  bit m_active = 1'b0;
  bit m_done   = 1'b0;
  int m_k = 0, m_hi = 1, m_lo = 1, m_len = 0;

  logic e_pwm, e_busy, e_done;
  int   e_rem;
  int   hi_clks, done_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_step();
    if (!rst) begin
      m_active = 1'b0;
      m_done   = 1'b0;
    end else if (m_active) begin
      if (bus.abort) begin
        m_active = 1'b0;
      end else if (bus.tick) begin
        m_k++;
        // Tick that ends the final high phase.
        if (m_k == (m_len - 1) * (m_hi + m_lo) + m_hi + 1) begin
          m_active = 1'b0;
          m_done   = 1'b1;
        end
      end
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (bus.start && (bus.burst_len != 0)) begin
      m_hi     = (bus.high_ticks == 0) ? 1 : int'(bus.high_ticks);
      m_lo     = (bus.low_ticks == 0) ? 1 : int'(bus.low_ticks);
      m_len    = int'(bus.burst_len);
      m_k      = 0;
      m_active = 1'b1;
    end
  endtask

  task automatic model_expect();
    int per, off, p, r;
    e_pwm = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_rem = 0;
    if (m_done) begin
      e_busy = 1'b1;
      e_done = 1'b1;
    end else if (m_active) begin
      e_busy = 1'b1;
      if (m_k == 0) begin
        e_rem = m_len;
      end else begin
        per   = m_hi + m_lo;
        off   = m_k - 1;
        p     = off / per;
        r     = off % per;
        e_pwm = (r < m_hi);
        e_rem = m_len - p - ((r >= m_hi) ? 1 : 0);
      end
    end
  endtask

  task automatic cyc();
    if (tper != 0) bus.tick = (tph == 0);
    else           bus.tick = ($urandom_range(0, 2) == 0);
    @(posedge clk);
    model_step();
    model_expect();
    if (tper != 0) tph = (tph + 1) % tper;
    #1;
    chk("pwm_out",   32'(bus.pwm_out),   32'(e_pwm));
    chk("busy",      32'(bus.busy),      32'(e_busy));
    chk("done",      32'(bus.done),      32'(e_done));
    chk("remaining", 32'(bus.remaining), 32'(e_rem));
    if (bus.pwm_out === 1'b1) hi_clks++;
    if (bus.done === 1'b1) done_cnt++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic cfg(input int hi, input int lo, input int len);
    bus.high_ticks = W'(hi);
    bus.low_ticks  = W'(lo);
    bus.burst_len  = C'(len);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
  endtask

  task automatic clr_counts();
    hi_clks  = 0;
    done_cnt = 0;
  endtask

  // Advance until the model says the pulse with the given remaining count is high.
  task automatic wait_high(input int rem, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      cyc();
      if (e_pwm && (e_rem == rem)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit ok;
    int n;
    bus.tick  = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    cfg(0, 0, 0);
    clr_counts();

    // Reset state.
    rst = 1'b0;
    run(2);
    rst = 1'b1;

    // Basic burst: 3 pulses of 2 ticks high, 1 tick low, tick every 5 clocks.
    tper = 5; tph = 1;
    cfg(2, 1, 3); clr_counts();
    pulse_start();
    run(60);
    chk("basic_high_clks", 32'(hi_clks), 32'd30);
    chk("basic_done_cnt", 32'(done_cnt), 32'd1);

    // Zero-length phases act as one tick.
    cfg(0, 0, 2); clr_counts();
    pulse_start();
    run(30);
    chk("zero_high_clks", 32'(hi_clks), 32'd10);
    chk("zero_done_cnt", 32'(done_cnt), 32'd1);

    // burst_len of zero is ignored.
    cfg(2, 1, 0); clr_counts();
    pulse_start();
    run(8);
    chk("len0_done_cnt", 32'(done_cnt), 32'd0);

    // Abort during the second high of a 4-pulse burst, then a normal burst.
    cfg(2, 1, 4); clr_counts();
    pulse_start();
    wait_high(3, ok);
    chk("abort_reach_second_high", 32'(ok), 32'd1);
    cyc();
    bus.abort = 1'b1;
    cyc();
    bus.abort = 1'b0;
    chk("abort_busy_low", 32'(bus.busy), 32'd0);
    run(40);
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    cfg(1, 2, 2); clr_counts();
    pulse_start();
    run(40);
    chk("post_abort_done_cnt", 32'(done_cnt), 32'd1);
    chk("post_abort_high_clks", 32'(hi_clks), 32'd10);

    // start coincident with tick: first rise waits for the next tick.
    for (int i = 0; i < 10 && tph != 0; i++) cyc();
    cfg(1, 1, 2); clr_counts();
    pulse_start();
    n = 0;
    for (int i = 0; i < 20; i++) begin
      n++;
      cyc();
      if (bus.pwm_out === 1'b1) break;
    end
    chk("start_tick_rise_delay", 32'(n), 32'd5);
    // start while busy is ignored.
    cfg(5, 5, 7);
    pulse_start();
    run(30);
    chk("busy_start_done_cnt", 32'(done_cnt), 32'd1);
    chk("busy_start_high_clks", 32'(hi_clks), 32'd10);

    // Reset mid-high.
    cfg(3, 1, 3); clr_counts();
    pulse_start();
    wait_high(3, ok);
    chk("rst_reach_high", 32'(ok), 32'd1);
    cyc();
    rst = 1'b0;
    cyc();
    chk("rst_pwm", 32'(bus.pwm_out), 32'd0);
    chk("rst_rem", 32'(bus.remaining), 32'd0);
    rst = 1'b1;
    run(10);
    chk("rst_stays_idle", 32'(bus.busy), 32'd0);

    // Config changes after acceptance do not affect the running burst.
    cfg(2, 1, 3); clr_counts();
    pulse_start();
    run(12);
    bus.high_ticks = 4'd7;
    run(60);
    chk("iso_high_clks", 32'(hi_clks), 32'd30);
    clr_counts();
    pulse_start();
    run(130);
    chk("iso_next_high_clks", 32'(hi_clks), 32'd105);

    // Random bursts, tick patterns, aborts, stray starts and config changes.
    for (int b = 0; b < 40; b++) begin
      case ($urandom_range(0, 4))
        0:       tper = 0;
        1:       tper = 1;
        2:       tper = 2;
        3:       tper = 3;
        default: tper = 5;
      endcase
      tph = 0;
      cfg($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 4));
      pulse_start();
      n = $urandom_range(20, 120);
      for (int i = 0; i < n; i++) begin
        bus.abort = ($urandom_range(0, 199) == 0);
        bus.start = ($urandom_range(0, 29) == 0);
        if ($urandom_range(0, 49) == 0)
          cfg($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 4));
        cyc();
      end
      bus.abort = 1'b0;
      bus.start = 1'b0;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/burst_sequencer.md
# burst_sequencer

Tick-driven burst sequencer sitting directly downstream of the team's periodic pulse generator. It consumes that generator's one-cycle `tick` strobe as its time base. On a `start` request it emits a programmable number of output pulses on `pwm_out`, each with a high phase and a low phase measured in ticks, then reports completion. It gives the design a gated, counted pulse train without reloading the upstream divider.

## Interface
- `WIDTH`, 4: width of the phase-length fields; matches the upstream generator's counter width.
- `CNT_W`, 8: width of the burst-length field and the remaining-pulse counter.

- `clk`  in  1  single system clock; all logic is posedge.
- `rst`  in  1  reset, synchronous, active-low; sampled on the `clk` rising edge.
- `tick`  in  1  one-cycle strobe from the upstream pulse generator; the only time base for phase lengths.
- `start`  in  1  request a burst; sampled only in IDLE.
- `abort`  in  1  cancel the burst in progress; level-sampled each cycle.
- `high_ticks`  in  WIDTH  high-phase length in ticks; 0 is treated as 1.
- `low_ticks`  in  WIDTH  low-phase length in ticks; 0 is treated as 1.
- `burst_len`  in  CNT_W  number of pulses; 0 means the start request is ignored.
- `pwm_out`  out  1  registered burst output.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle strobe at normal completion.
- `remaining`  out  CNT_W  pulses not yet started, including the one currently high.

## Operation
- FSM states: IDLE, ARM, HIGH, LOW, DONE.
- **IDLE**
  - Condition: `start`=1 and `burst_len`≠0.
  - Action: latch `high_ticks`, `low_ticks` and `burst_len`; `remaining`←`burst_len`; clear the phase counter; go to ARM.
  - Otherwise stay in IDLE.
- **ARM**
  - Waits for the next `tick`.
  - On `tick`: go to HIGH and clear the phase counter.
- **HIGH**
  - Each `tick` increments the phase counter.
  - On the tick where the count equals hi_eff−1: clear the counter and decrement `remaining`.
  - If `remaining` was 1, go to DONE; otherwise go to LOW.
- **LOW**
  - Each `tick` increments the phase counter.
  - On the tick where the count equals lo_eff−1: clear the counter and go to HIGH.
- **DONE**
  - Lasts one cycle, then goes to IDLE.
- The last pulse has no trailing LOW phase.
- hi_eff = max(latched `high_ticks`, 1); lo_eff = max(latched `low_ticks`, 1).
- Input config changes after acceptance have no effect until the next accepted `start`.
- Outputs are registered from next-state:
  - `pwm_out` = 1 exactly while the state is HIGH.
  - `busy` = 1 while the state is not IDLE.
  - `done` = 1 while the state is DONE.
- `abort`=1 in any non-IDLE state forces IDLE on the next edge:
  - `pwm_out` and `busy` go to 0 on that edge.
  - `done` is not asserted.
  - `remaining` is cleared to 0.
- Simultaneous events:
  - `start` while not in IDLE is ignored; no queueing.
  - `start` and `tick` in the same IDLE cycle: start is accepted, the tick is not counted, and ARM waits for a later tick.
  - `abort` and `tick` in the same cycle: abort wins.
  - `abort` and `start` in IDLE: start wins, because abort has no effect in IDLE.
- Phase counter is WIDTH bits and never wraps, because it is bounded by hi_eff−1 or lo_eff−1.
- `remaining` never underflows.

## Timing
- Reset (`rst`=0 at an edge): state IDLE, `pwm_out`=0, `busy`=0, `done`=0, `remaining`=0, phase counter 0, latched config 0.
- Reset has priority over all other inputs, mid-burst included; the effect is visible the cycle after the edge.
- Start latency: `start` accepted at edge N → `busy`=1 after edge N.
- Output rise: `tick` high at edge M while in ARM or LOW → `pwm_out`=1 after edge M.
- Output fall: the final high tick at edge K → `pwm_out`=0 after edge K.
- Done timing: `done`=1 for the cycle after the last pulse's falling edge; `busy` drops one cycle later.
- Pulse shape: high lasts hi_eff tick periods and low lasts lo_eff tick periods, both measured tick-edge to tick-edge.

## Structure
- Shared package `pulse_pkg` holds:
  - the state enum typedef (IDLE, ARM, HIGH, LOW, DONE);
  - default localparams for WIDTH and CNT_W.
- Single flat module; no sub-module.
- The upstream pulse generator is instantiated alongside at the parent level, with its `pulse` wired to `tick`.

## Test plan
- **Basic burst:** tick every 5 clocks; `high_ticks`=2, `low_ticks`=1, `burst_len`=3.
  - Expect three high pulses of 10 clocks, separated by 5-clock lows.
  - Expect `done` one cycle after the third fall, then `busy`=0; `remaining` reads 3,2,1,0.
- **Zero fields:** `high_ticks`=0, `low_ticks`=0, `burst_len`=2.
  - Expect both phases to behave as 1 tick: two 5-clock highs with one 5-clock gap.
  - `burst_len`=0 with `start` → `busy` stays 0.
- **Abort:** `abort` during the second HIGH of a 4-pulse burst.
  - Expect `pwm_out`=0, `busy`=0, `remaining`=0 the next cycle, and no `done`.
  - A subsequent `start` must run normally.
- **Collisions:**
  - `start` in the same cycle as `tick` → the first rise waits for the following tick (5 clocks later).
  - `start` while busy → ignored; the burst is unchanged.
- **Mid-burst reset:** `rst`=0 for one edge mid-HIGH.
  - Expect all outputs 0 the next cycle.
  - Reasserting `rst`=1 with `start` held low keeps the block in IDLE.
- **Config isolation:** change `high_ticks` from 2 to 7 mid-burst → pulse widths stay at 2 ticks until the next `start`.
